// File: rtl/instruction_fetch.sv
// Instruction fetch stage: reads two ROM bytes per instruction (big-endian) and hands
// the word to the control FSM over valid/ack. Optional opcode halt via FETCH_HLT_DETECT_EN.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic [15:0]           Fetch,
  output logic                  instr_valid,
  input  logic                  instr_ack,
  output logic [ADDR_WIDTH-1:0] pc_out,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  input  logic                  halt,
  output logic                  halted
);

  localparam logic [2:0] S_ADDR_HI = 3'd0;
  localparam logic [2:0] S_CAPT_HI = 3'd1;
  localparam logic [2:0] S_CAPT_LO = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_TWO  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] PC_INIT = {RESET_PC[ADDR_WIDTH-1:1], 1'b0};
  localparam logic [15:0]           HLT_WORD = 16'hD000;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           fetch_q, fetch_d;
  logic                  hlt_seen;
  logic                  unused_redirect_lsb;

`ifdef FETCH_HLT_DETECT_EN
  localparam logic [3:0] HLT_OPCODE = 4'hD;
  assign hlt_seen = (fetch_q[15:12] == HLT_OPCODE);
`else
  assign hlt_seen = 1'b0;
`endif

  // Instructions are halfword aligned, so the target LSB carries no information.
  assign unused_redirect_lsb = redirect_addr[0];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fetch_d  = fetch_q;
    rom_addr = pc_q;

    case (state_q)
      S_ADDR_HI: begin
        rom_addr = pc_q;
        state_d  = S_CAPT_HI;
      end
      S_CAPT_HI: begin
        rom_addr       = pc_q + PC_ONE;
        fetch_d[15:8]  = rom_data;
        state_d        = S_CAPT_LO;
      end
      S_CAPT_LO: begin
        rom_addr      = pc_q + PC_ONE;
        fetch_d[7:0]  = rom_data;
        state_d       = S_HOLD;
      end
      S_HOLD: begin
        // Present the next high-byte address now so the ROM output is ready on ack.
        rom_addr = pc_q + PC_TWO;
        if (instr_ack) begin
          if (hlt_seen) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_q + PC_TWO;
            state_d = S_CAPT_HI;
          end
        end
      end
      S_HALT: begin
        rom_addr = pc_q;
      end
      default: begin
        rom_addr = pc_q;
        state_d  = S_ADDR_HI;
      end
    endcase

    if (state_q != S_HALT) begin
      if (halt) begin
        state_d = S_HALT;
        pc_d    = pc_q;
        fetch_d = fetch_q;
      end else if (redirect_valid) begin
        pc_d    = {redirect_addr[ADDR_WIDTH-1:1], 1'b0};
        fetch_d = fetch_q;
        state_d = S_ADDR_HI;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ADDR_HI;
      pc_q    <= PC_INIT;
      fetch_q <= HLT_WORD;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fetch_q <= fetch_d;
    end
  end

  assign Fetch       = fetch_q;
  assign pc_out      = pc_q;
  assign instr_valid = (state_q == S_HOLD);
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a driver issues ack/redirect/halt/reset and
// predicts each presented instruction; a monitor pops and checks when valid appears.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  rom_addr, rom_data;
  logic [15:0] fetch;
  logic        instr_valid, instr_ack;
  logic [7:0]  pc_out;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        halt, halted;

  logic [7:0]  rom_addr2, rom_data2;
  logic [15:0] fetch2;
  logic        valid2, halted2;
  logic [7:0]  pc_out2;

  logic [7:0]  rom [256];

  instruction_fetch #(.ADDR_WIDTH(8), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data), .Fetch(fetch),
    .instr_valid(instr_valid), .instr_ack(instr_ack), .pc_out(pc_out),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .halt(halt), .halted(halted)
  );

  instruction_fetch #(.ADDR_WIDTH(8), .RESET_PC(8'hFE)) u_wrap (
    .clk(clk), .rst(rst), .rom_addr(rom_addr2), .rom_data(rom_data2), .Fetch(fetch2),
    .instr_valid(valid2), .instr_ack(1'b1), .pc_out(pc_out2),
    .redirect_valid(1'b0), .redirect_addr(8'h00),
    .halt(1'b0), .halted(halted2)
  );

  always @(posedge clk) begin
    rom_data  <= rom[rom_addr];
    rom_data2 <= rom[rom_addr2];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef FETCH_HLT_DETECT_EN
  localparam bit HLT_DET = 1'b1;
`else
  localparam bit HLT_DET = 1'b0;
`endif

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
    int          due;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  int         checks = 0;
  int         errors = 0;
  int         pop_count = 0;
  int         clear_count = 0;
  logic [7:0] m_pc = 8'h00;
  bit         halt_pending = 1'b0;
  int         halt_cyc = 0;
  logic [7:0] halt_pc = 8'h00;
  bit         wrap_on = 1'b0;
  int         wrap_k0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] pc, input int due);
    exp_t e;
    logic [7:0] lo;
    lo = pc + 8'd1;
    e.pc = pc;
    e.instr = {rom[pc], rom[lo]};
    e.due = due;
    return e;
  endfunction

  // Driver and reference model: one call per clock interval, inputs change 2 time units after the edge.
  task automatic step(input bit r, input bit a, input bit rv, input logic [7:0] ra, input bit h);
    int k;
    k = cyc;
    if (r) begin
      rst = 1'b1;
      instr_ack = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'h00; halt = 1'b0;
      exp_q.delete();
      clear_count = pop_count;
      halt_pending = 1'b0;
      m_pc = 8'h00;
    end else if (rst) begin
      rst = 1'b0;
      instr_ack = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'h00; halt = 1'b0;
      exp_q.push_back(mk(m_pc, k + 3));
      if (!wrap_on) begin
        wrap_on = 1'b1;
        wrap_k0 = k;
      end
    end else begin
      instr_ack = a; redirect_valid = rv; redirect_addr = ra; halt = h;
      if (!halt_pending) begin
        if (h) begin
          halt_pending = 1'b1; halt_cyc = k; halt_pc = m_pc;
          exp_q.delete();
          clear_count = pop_count;
        end else if (rv) begin
          m_pc = {ra[7:1], 1'b0};
          exp_q.delete();
          clear_count = pop_count;
          exp_q.push_back(mk(m_pc, k + 4));
        end else if (a && (pop_count != clear_count)) begin
          clear_count = pop_count;
          if (HLT_DET && cur.instr[15:12] == 4'hD) begin
            halt_pending = 1'b1; halt_cyc = k; halt_pc = m_pc;
          end else begin
            m_pc = m_pc + 8'd2;
            exp_q.push_back(mk(m_pc, k + 3));
          end
        end
      end
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor: samples 1 time unit after each edge, before the driver moves.
  initial begin
    exp_t e;
    bit   presented;
    bit   exp_h;
    forever begin
      @(posedge clk);
      #1;
      presented = (pop_count != clear_count);
      if (rst) begin
        check("reset_valid", instr_valid, 0);
        check("reset_halted", halted, 0);
        check("reset_pc", pc_out, 8'h00);
        check("reset_fetch", fetch, 16'hD000);
      end else begin
        exp_h = halt_pending && (cyc > halt_cyc);
        check("halted", halted, exp_h);
        if (exp_h) begin
          check("halt_valid", instr_valid, 0);
          check("halt_pc", pc_out, halt_pc);
          check("halt_rom_addr", rom_addr, halt_pc);
        end else if (instr_valid) begin
          if (!presented) begin
            if (exp_q.size() == 0) begin
              check("spurious_valid", instr_valid, 0);
            end else begin
              e = exp_q.pop_front();
              cur = e;
              pop_count++;
              presented = 1'b1;
              check("valid_cycle", cyc, e.due);
              check("fetch_pc", pc_out, e.pc);
              check("fetch_word", fetch, e.instr);
              $display("txn cycle=%0d pc=%02h instr=%04h", cyc, pc_out, fetch);
            end
          end else begin
            check("hold_pc", pc_out, cur.pc);
            check("hold_fetch", fetch, cur.instr);
          end
          if (presented) check("prefetch_addr", rom_addr, 8'(cur.pc + 8'd2));
        end else begin
          if (presented) check("valid_drop", instr_valid, 1);
          if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            check("valid_late", instr_valid, 1);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // Wrap-around instance (RESET_PC=0xFE) after the first reset release.
  initial begin
    int idx;
    logic [7:0] ea;
    forever begin
      @(posedge clk);
      #3;
      if (wrap_on && !rst) begin
        idx = cyc - wrap_k0;
        if (idx >= 0 && idx <= 6) begin
          case (idx)
            0:       ea = 8'hFE;
            1, 2:    ea = 8'hFF;
            3:       ea = 8'h00;
            4, 5:    ea = 8'h01;
            default: ea = 8'h02;
          endcase
          check("wrap_rom_addr", rom_addr2, ea);
          if (idx == 3) begin
            check("wrap_valid", valid2, 1);
            check("wrap_pc0", pc_out2, 8'hFE);
            check("wrap_fetch0", fetch2, 16'h1122);
          end else if (idx == 6) begin
            check("wrap_valid", valid2, 1);
            check("wrap_pc1", pc_out2, 8'h00);
            check("wrap_fetch1", fetch2, 16'h1234);
          end else begin
            check("wrap_valid", valid2, 0);
          end
        end
      end
    end
  end

  initial begin
    int wait_lim;
    rst = 1'b1;
    instr_ack = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'h00; halt = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[8'h00] = 8'h12; rom[8'h01] = 8'h34;
    rom[8'h02] = 8'h56; rom[8'h03] = 8'h78;
    rom[8'h04] = 8'hD0; rom[8'h05] = 8'h00;
    rom[8'h06] = 8'h9A; rom[8'h07] = 8'hBC;
    rom[8'h40] = 8'h4A; rom[8'h41] = 8'h5B;
    rom[8'hFE] = 8'h11; rom[8'hFF] = 8'h22;
    repeat (2) @(posedge clk);
    #2;

    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);
    repeat (5) step(0, 1, 0, 8'h00, 0);
    repeat (5) step(0, 0, 0, 8'h00, 0);
    step(0, 1, 0, 8'h00, 0);
    step(0, 1, 1, 8'h41, 0);
    repeat (4) step(0, 1, 0, 8'h00, 0);
    step(0, 0, 1, 8'h04, 0);
    repeat (3) step(0, 0, 0, 8'h00, 0);
    step(0, 1, 0, 8'h00, 0);
    repeat (3) step(0, 0, 0, 8'h00, 0);
    step(0, 1, 1, 8'h80, 1);
    repeat (5) step(0, 1, 1, 8'($urandom), 0);
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);

    wait_lim = 6 + $urandom_range(0, 5);
    for (int n = 0; n < 4000; n++) begin
      if (halt_pending && (cyc - halt_cyc > wait_lim)) begin
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        wait_lim = 6 + $urandom_range(0, 5);
      end else if ($urandom_range(0, 299) == 0) begin
        repeat ($urandom_range(1, 3)) step(1, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
      end else begin
        step(0, ($urandom % 3) != 0, ($urandom % 12) == 0, 8'($urandom), ($urandom % 90) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Upstream stage of the instruction decoder. Reads the 16-bit instruction as two consecutive bytes from the 8-bit synchronous program ROM.
- Assembles the two bytes big-endian: high byte at the even address.
- Presents the assembled word on Fetch with a valid/ack handshake to the control FSM, which drives the decoder.
- Owns the program counter and accepts branch/jump redirects and halt from the control path.

Parameters:
- ADDR_WIDTH, 8, ROM byte-address width; PC width.
- RESET_PC, 0, PC value loaded on reset (LSB ignored, forced 0).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- rom_addr  output  ADDR_WIDTH  byte address to ROM (combinational from state/PC).
- rom_data  input  8  ROM read data; reflects rom_addr sampled at the previous rising edge.
- Fetch  output  16  assembled instruction to the decoder.
- instr_valid  output  1  Fetch holds a complete instruction.
- instr_ack  input  1  consumer accepts Fetch this cycle; ignored unless instr_valid=1.
- pc_out  output  ADDR_WIDTH  address of the instruction currently in Fetch.
- redirect_valid  input  1  load redirect_addr into PC, abort the in-flight fetch.
- redirect_addr  input  ADDR_WIDTH  branch/jump target (LSB forced 0).
- halt  input  1  enter HALTED.
- halted  output  1  fetch stopped.

Behaviour:
- Reset values, asynchronous, held while rst=1:
  - state=S_ADDR_HI, PC=RESET_PC&~1, Fetch=16'hD000 (HLT encoding).
  - instr_valid=0, halted=0, pc_out=PC.
- Interface is the register state only; rom_addr is not separately reset.

States and rom_addr:
- S_ADDR_HI: rom_addr=PC. Next state S_CAPT_HI.
- S_CAPT_HI: rom_addr=PC+1. On the clock edge Fetch[15:8]<=rom_data. Next state S_CAPT_LO.
- S_CAPT_LO: rom_addr=PC+1. On the clock edge Fetch[7:0]<=rom_data. Next state S_HOLD.
- S_HOLD: instr_valid=1, rom_addr=PC+2 (prefetch of the next high byte).
  - instr_ack=1: PC<=PC+2, next state S_CAPT_HI.
  - instr_ack=0: remain in S_HOLD; Fetch and pc_out stable.
- S_HALT: instr_valid=0, halted=1, rom_addr=PC. Exits only via rst.

Timing:
- instr_valid is asserted only in S_HOLD.
- First valid instruction appears 3 cycles after reset release.
- Steady state with ack asserted every valid cycle: one instruction per 3 cycles.

Address arithmetic:
- All PC arithmetic is modulo 2^ADDR_WIDTH.
- PC=0xFE: high byte from 0xFE, low byte from 0xFF, next PC=0x00.

Priority per cycle, in all states except S_HALT:
- halt > redirect_valid > instr_ack.
- halt: next state S_HALT; PC and Fetch unchanged.
- redirect_valid: PC<=redirect_addr&~1, next state S_ADDR_HI, instr_valid drops the following cycle. Any partial capture is discarded: Fetch bytes may be overwritten by the next fetch but are never flagged valid.
- redirect_valid together with instr_ack in S_HOLD: redirect wins, no PC+2.
- In S_HALT, redirect_valid and instr_ack are ignored.

Reset mid-operation: immediate return to reset values; no partial instruction is ever presented.

Optional Feature:
Macro: FETCH_HLT_DETECT_EN
- Defined: in S_HOLD, if Fetch[15:12]==4'b1101 and instr_ack=1 (and no redirect), next state is S_HALT with PC unchanged, instead of PC+2/S_CAPT_HI. Fetch stops without waiting for the halt input.
- Undefined: no opcode inspection; fetch continues at PC+2 until the halt input.

Test Plan:
- ROM[0]=0x12, ROM[1]=0x34, release rst, instr_ack=1 -> instr_valid=1 on cycle 3 with Fetch=0x1234, pc_out=0x00; next valid on cycle 6 with pc_out=0x02.
- instr_ack=0 for 5 cycles in S_HOLD -> Fetch, pc_out and instr_valid stable; rom_addr=PC+2; ack -> pc_out advances by exactly 2.
- redirect_valid=1 with redirect_addr=0x41 during S_CAPT_HI -> instr_valid stays 0; next valid Fetch={ROM[0x40],ROM[0x41]}, pc_out=0x40.
- RESET_PC=0xFE, ack every valid -> instructions at 0xFE, then 0x00; rom_addr sequence 0xFE,0xFF,0x00,0x01.
- halt=1 together with redirect_valid=1 and instr_ack=1 in S_HOLD -> halted=1, instr_valid=0, PC unchanged; later redirect ignored; rst restores RESET_PC.
- With FETCH_HLT_DETECT_EN, ROM holds 0xD0,0x00 at 0x04 -> after ack of that instruction halted=1, no further valid; without the macro, the next instruction from 0x06 is presented.
